// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, one-outstanding imem read, redirect/stall/flush, IF/ID register.
// Define FETCH_PERF_CNT_EN to add the FetchStallCnt output (saturating count of fetch stall cycles).
module fetch_stage #(
    parameter logic [17:0] RESET_PC = 18'd0,
    parameter logic [17:0] PC_STEP  = 18'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [17:0] PCTargetE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        IMemReq,
    output logic [17:0] IMemAddr,
    input  logic        IMemValid,
    input  logic [32:0] IMemRData,
    output logic [32:0] InstrD,
    output logic [17:0] PCD,
    output logic [17:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] FetchStallCnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_RSP, HOLD} state_t;

    state_t      state, state_nx;
    logic [17:0] pc_f, pc_f_nx;
    logic [17:0] req_addr, req_addr_nx;
    logic        stale, stale_nx;
    logic [32:0] buf_instr, buf_instr_nx;
    logic [17:0] buf_pc, buf_pc_nx;
    logic        load;
    logic [32:0] load_instr;
    logic [17:0] load_pc;

    // Request outputs come straight from registers, never from inputs.
    assign IMemReq  = (state == WAIT_RSP);
    assign IMemAddr = req_addr;

    always_comb begin
        state_nx     = state;
        pc_f_nx      = pc_f;
        req_addr_nx  = req_addr;
        stale_nx     = stale;
        buf_instr_nx = buf_instr;
        buf_pc_nx    = buf_pc;
        load         = 1'b0;
        load_instr   = '0;
        load_pc      = '0;
        if (PCSrcE) begin
            pc_f_nx = PCTargetE;
            if (state == WAIT_RSP && !IMemValid) begin
                // Keep the request up so the in-flight read drains, then drop it.
                stale_nx = 1'b1;
            end else begin
                stale_nx = 1'b0;
                state_nx = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!StallF) begin
                        req_addr_nx = pc_f;
                        state_nx    = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (IMemValid) begin
                        if (stale) begin
                            stale_nx = 1'b0;
                            state_nx = IDLE;
                        end else if (!StallD) begin
                            load       = 1'b1;
                            load_instr = IMemRData;
                            load_pc    = req_addr;
                            pc_f_nx    = req_addr + PC_STEP;
                            if (!StallF) begin
                                req_addr_nx = req_addr + PC_STEP;
                            end else begin
                                state_nx = IDLE;
                            end
                        end else begin
                            buf_instr_nx = IMemRData;
                            buf_pc_nx    = req_addr;
                            state_nx     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!StallD) begin
                        load       = 1'b1;
                        load_instr = buf_instr;
                        load_pc    = buf_pc;
                        pc_f_nx    = buf_pc + PC_STEP;
                        state_nx   = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc_f      <= RESET_PC;
            req_addr  <= '0;
            stale     <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else begin
            state     <= state_nx;
            pc_f      <= pc_f_nx;
            req_addr  <= req_addr_nx;
            stale     <= stale_nx;
            buf_instr <= buf_instr_nx;
            buf_pc    <= buf_pc_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (load) begin
            InstrD   <= load_instr;
            PCD      <= load_pc;
            PCPlus4D <= load_pc + PC_STEP;
            ValidD   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = (state == WAIT_RSP && !IMemValid) || (state == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            FetchStallCnt <= '0;
        end else if (stall_cycle && FetchStallCnt != '1) begin
            FetchStallCnt <= FetchStallCnt + 16'd1;
        end
    end
`endif

endmodule
